// File: rtl/dice_pkg.sv
// ============================================================================
// Module  : dice_pkg
// Brief   : Shared types and helpers for the multi-die turn controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dice_pkg;

  localparam int RL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    DONE = 2'd2
  } turn_state_e;

  function automatic int val_w(input int faces);
    return $clog2(faces + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dice_debounce.sv
// ============================================================================
// Module  : dice_debounce
// Brief   : Two-flop synchroniser, consecutive-sample debounce, registered fall pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dice_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall_pulse
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_dly_q;
  logic             fall_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      fall_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= din;
      sync2_q     <= sync1_q;
      level_dly_q <= level_q;
      fall_q      <= level_dly_q & ~level_q;
      // Any sample agreeing with the accepted level restarts the count.
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level      = level_q;
  assign fall_pulse = fall_q;

endmodule

`default_nettype wire

// File: rtl/dice_turn_controller.sv
// ============================================================================
// Module  : dice_turn_controller
// Brief   : Odometer dice, debounced roll button and per-turn hold/capture FSM.
//           Optional registered dice_sum output when DICE_SUM_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dice_turn_controller
  import dice_pkg::*;
#(
  parameter int NUM_DICE   = 5,
  parameter int FACES      = 6,
  parameter int DEB_CYCLES = 4,
  parameter int MAX_ROLLS  = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   roll_btn,
  input  logic [NUM_DICE-1:0]                    hold_mask,
  input  logic                                   new_turn,
  output logic [NUM_DICE*val_w(FACES)-1:0]       stored_values,
  output logic                                   rolled,
  output logic [RL_W-1:0]                        rolls_left,
  output logic                                   turn_done
`ifdef DICE_SUM_EN
  ,
  output logic [$clog2(NUM_DICE*FACES+1)-1:0]    dice_sum
`endif
);

  localparam int VAL_W = val_w(FACES);
  localparam logic [VAL_W-1:0] FACE_MAX  = VAL_W'(FACES);
  localparam logic [RL_W-1:0]  ROLLS_MAX = RL_W'(MAX_ROLLS);

  logic                roll_req;
  logic [VAL_W-1:0]    run_q [NUM_DICE];
  logic [NUM_DICE-1:0] step;
  logic [NUM_DICE-1:0] wrap;

  dice_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (roll_btn),
    .level     (),
    .fall_pulse(roll_req)
  );

  // Odometer: die i advances only when every lower die wraps this cycle.
  for (genvar gi = 0; gi < NUM_DICE; gi++) begin : g_die
    assign wrap[gi] = (run_q[gi] == FACE_MAX);
    if (gi == 0) begin : g_first
      assign step[gi] = 1'b1;
    end else begin : g_rest
      assign step[gi] = step[gi-1] & wrap[gi-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        run_q[gi] <= VAL_W'(1);
      end else if (step[gi]) begin
        run_q[gi] <= wrap[gi] ? VAL_W'(1) : run_q[gi] + 1'b1;
      end
    end
  end

  turn_state_e                   state_q, state_d;
  logic [RL_W-1:0]               left_q, left_d;
  logic [NUM_DICE*VAL_W-1:0]     stored_q, stored_d;
  logic                          rolled_q, rolled_d;
  logic [NUM_DICE-1:0]           cap_en;

  always_comb begin
    state_d  = state_q;
    left_d   = left_q;
    stored_d = stored_q;
    rolled_d = 1'b0;
    cap_en   = '0;
    // new_turn has priority; a coincident roll request is dropped.
    if (new_turn) begin
      state_d = IDLE;
      left_d  = ROLLS_MAX;
    end else if (roll_req) begin
      case (state_q)
        IDLE: begin
          cap_en   = '1;
          rolled_d = 1'b1;
          left_d   = ROLLS_MAX - 1'b1;
          state_d  = (MAX_ROLLS == 1) ? DONE : TURN;
        end
        TURN: begin
          cap_en   = ~hold_mask;
          rolled_d = 1'b1;
          left_d   = left_q - 1'b1;
          state_d  = (left_q == RL_W'(1)) ? DONE : TURN;
        end
        default: ;
      endcase
    end
    for (int i = 0; i < NUM_DICE; i++) begin
      if (cap_en[i]) begin
        stored_d[i*VAL_W +: VAL_W] = run_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      left_q   <= ROLLS_MAX;
      stored_q <= '0;
      rolled_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      stored_q <= stored_d;
      rolled_q <= rolled_d;
    end
  end

  assign stored_values = stored_q;
  assign rolled        = rolled_q;
  assign rolls_left    = left_q;
  assign turn_done     = (state_q == DONE);

`ifdef DICE_SUM_EN
  localparam int SUM_W = $clog2(NUM_DICE*FACES+1);

  logic [SUM_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_DICE; i++) begin
      sum_d = sum_d + SUM_W'(stored_d[i*VAL_W +: VAL_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign dice_sum = sum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dice_turn_controller.sv
// ============================================================================
// Module  : tb_dice_turn_controller
// Brief   : Directed, table-driven bench for dice_turn_controller (defaults).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dice_turn_controller;

  localparam int ND = 5;
  localparam int FC = 6;
  localparam int VW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            roll_btn = 1'b0;
  logic [ND-1:0]   hold_mask = '0;
  logic            new_turn = 1'b0;
  logic [ND*VW-1:0] stored_values;
  logic            rolled;
  logic [2:0]      rolls_left;
  logic            turn_done;
`ifdef DICE_SUM_EN
  logic [4:0]      dice_sum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dice_turn_controller #(
    .NUM_DICE(ND), .FACES(FC), .DEB_CYCLES(4), .MAX_ROLLS(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .roll_btn     (roll_btn),
    .hold_mask    (hold_mask),
    .new_turn     (new_turn),
    .stored_values(stored_values),
    .rolled       (rolled),
    .rolls_left   (rolls_left),
    .turn_done    (turn_done)
`ifdef DICE_SUM_EN
    ,
    .dice_sum     (dice_sum)
`endif
  );

  // Reference odometer; prev holds the values that were live in the cycle just ended.
  int run [ND];
  int prev[ND];
  bit mc  [ND];

  always_comb begin
    mc[0] = 1'b1;
    for (int i = 1; i < ND; i++) mc[i] = mc[i-1] && (run[i-1] == FC);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ND; i++) begin
        run[i]  <= 1;
        prev[i] <= 1;
      end
    end else begin
      for (int i = 0; i < ND; i++) begin
        prev[i] <= run[i];
        if (mc[i]) run[i] <= (run[i] == FC) ? 1 : run[i] + 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit          nt_before;
    int          nt_at;
    int          hi;
    int          lo;
    bit          rehigh;
    logic [ND-1:0] mask;
    int          exp_roll;
    logic [ND-1:0] cap;
    int          exp_left;
    int          exp_done;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    logic [ND*VW-1:0] snap;
    int nroll;
    int at;
    int esum;
    int ev;
    if (v.nt_before) begin
      @(negedge clk); new_turn = 1'b1;
      @(negedge clk); new_turn = 1'b0;
      check($sformatf("v%0d new_turn rolls_left", idx), rolls_left, 3);
      check($sformatf("v%0d new_turn turn_done", idx), turn_done, 0);
    end
    hold_mask = v.mask;
    roll_btn  = 1'b1;
    repeat (v.hi) @(negedge clk);
    snap     = stored_values;
    roll_btn = 1'b0;
    nroll    = 0;
    at       = 0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (v.nt_at != 0 && j == v.nt_at + 1) new_turn = 1'b0;
      if (rolled) begin
        nroll++;
        at   = j;
        esum = 0;
        for (int i = 0; i < ND; i++) begin
          ev = v.cap[i] ? prev[i] : int'(snap[i*VW +: VW]);
          esum += ev;
          check($sformatf("v%0d die%0d", idx, i), stored_values[i*VW +: VW], ev);
        end
`ifdef DICE_SUM_EN
        check($sformatf("v%0d dice_sum", idx), dice_sum, esum);
`endif
      end
      if (v.nt_at != 0 && j == v.nt_at) new_turn = 1'b1;
      if (v.rehigh && j == v.lo) roll_btn = 1'b1;
    end
    check($sformatf("v%0d rolled count", idx), nroll, v.exp_roll);
    if (v.exp_roll == 1) check($sformatf("v%0d rolled latency", idx), at, 8);
    if (v.exp_roll == 0) check($sformatf("v%0d stored kept", idx), stored_values, snap);
    check($sformatf("v%0d rolls_left", idx), rolls_left, v.exp_left);
    check($sformatf("v%0d turn_done", idx), turn_done, v.exp_done);
  endtask

  vec_t vecs[11];

  initial begin
    int cnt;
    //            nt  at  hi  lo rh  mask      roll cap       left done
    vecs[0]  = '{0, 0, 20, 16, 0, 5'b00000, 1, 5'b11111, 2, 0};
    vecs[1]  = '{0, 0, 20, 16, 0, 5'b10101, 1, 5'b01010, 1, 0};
    vecs[2]  = '{0, 0, 20, 16, 0, 5'b10101, 1, 5'b01010, 0, 1};
    vecs[3]  = '{0, 0, 20, 16, 0, 5'b00000, 0, 5'b00000, 0, 1};
    vecs[4]  = '{1, 0, 20,  1, 1, 5'b00000, 0, 5'b00000, 3, 0};
    vecs[5]  = '{0, 0, 20,  2, 1, 5'b00000, 0, 5'b00000, 3, 0};
    vecs[6]  = '{0, 0, 20,  3, 1, 5'b00000, 0, 5'b00000, 3, 0};
    vecs[7]  = '{0, 0, 20,  4, 1, 5'b00000, 1, 5'b11111, 2, 0};
    vecs[8]  = '{0, 0, 20, 16, 0, 5'b11111, 1, 5'b00000, 1, 0};
    vecs[9]  = '{0, 7, 20, 16, 0, 5'b00000, 0, 5'b00000, 3, 0};
    vecs[10] = '{0, 0, 20, 16, 0, 5'b11111, 1, 5'b11111, 2, 0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (rolled) cnt++;
    end
    check("reset rolled pulses", cnt, 0);
    check("reset stored_values", stored_values, 0);
    check("reset rolls_left", rolls_left, 3);
    check("reset turn_done", turn_done, 0);
`ifdef DICE_SUM_EN
    check("reset dice_sum", dice_sum, 0);
`endif

    for (int k = 0; k < 11; k++) run_vec(vecs[k], k);

    // Reset asserted while a release is still being debounced.
    roll_btn = 1'b1;
    repeat (20) @(negedge clk);
    roll_btn = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (rolled) cnt++;
    end
    check("midreset rolled pulses", cnt, 0);
    check("midreset stored_values", stored_values, 0);
    check("midreset rolls_left", rolls_left, 3);
    check("midreset turn_done", turn_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
